uart_rx_controller: RTL and testbench
=====================================

// Module: uart_rx_controller
// PURPOSE
//  Sequencing controller for the UART receive path. Detects the start bit on the serial line.
//  Times mid-bit sample points from a runtime baud divisor and shifts 8 data bits in LSB-first.
//  Checks the stop bit, then presents the byte to the core (MMIO UART block) over a valid/ready handshake.
//  Replaces free-running baud-clock shifting with a single-clock-domain, sample-point-accurate FSM.
// PARAMETERS
//  DATA_BITS    8   data bits per frame, LSB first
//  SYNC_STAGES  2   flops in rx_in metastability synchronizer (>=2)
//  DIV_W        32  width of baud_divisor
// PORTS
//  clk           in   1          system clock, all logic on posedge
//  rst           in   1          reset, asynchronous, active-high
//  rx_en         in   1          receiver enable; 0 forces IDLE
//  rx_in         in   1          serial line, idle high, asynchronous to clk
//  baud_divisor  in   DIV_W      clk cycles per bit; values <4 treated as 4
//  rx_ready      in   1          consumer accepts rx_data when rx_valid&rx_ready
//  clr_err       in   1          1-cycle pulse clears frame_err and overrun
//  rx_data       out  DATA_BITS  received byte, stable while rx_valid=1
//  rx_valid      out  1          byte available
//  frame_err     out  1          sticky: stop bit sampled low
//  overrun       out  1          sticky: frame completed while rx_valid=1
//  busy          out  1          1 in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE, counters 0, synchronizer flops preset to 1 (line idle).
//  Sync: rx_s = rx_in after SYNC_STAGES flops. Falling edge = rx_s==0 && rx_s_d==1.
//  Divisor latched into div_q on IDLE->START; mid-frame baud_divisor changes are ignored.
//  Bit counter cnt counts clk cycles; tick when cnt==target-1, then cnt<=0.
//  FSM:
//   IDLE : rx_en && falling edge -> START; latch div_q; cnt<=0.
//   START: target=div_q>>1 (mid start bit). On tick: rx_s==0 -> DATA, bit_idx<=0;
//          rx_s==1 -> IDLE (glitch, no flags).
//   DATA : target=div_q. On tick: shift rx_s into shreg MSB, shift right.
//          bit_idx==DATA_BITS-1 -> STOP, else bit_idx++.
//   STOP : target=div_q. On tick:
//          rx_s==1 && !rx_valid -> rx_data<=shreg, rx_valid<=1.
//          rx_s==1 && rx_valid -> overrun<=1; held byte kept, new byte dropped.
//          rx_s==0 -> frame_err<=1, byte discarded.
//          Always -> IDLE; the next falling edge is accepted in the same cycle the FSM returns to IDLE.
//  Latency: rx_valid rises exactly SYNC_STAGES+1 + div_q/2 + (DATA_BITS+1)*div_q clk cycles after
//   the rx_in falling edge, when the edge is set up before a clk edge.
//  Handshake: rx_valid holds until the cycle after rx_valid&&rx_ready; rx_data is unchanged meanwhile.
//   If a new byte and a consume land in the same cycle, the consume wins; the new byte counts as overrun.
//  clr_err clears both sticky flags. A set event in the same cycle as clr_err wins (flag ends at 1).
//  rx_en=0 mid-frame: next cycle FSM=IDLE, partial byte discarded, no flags.
//   rx_valid and the held rx_data are unaffected.
//  rst asserted mid-frame: immediate return to reset state; no partial byte is ever presented.
// TESTING
//  1 div=16, send 0xA5 (8N1), rx_ready=1 -> rx_valid 1 cycle, rx_data=0xA5,
//    latency 3+8+144=155 cycles after edge.
//  2 div=16, 0x3C then 0xC3 back-to-back, rx_ready=0 -> rx_data=0x3C held, overrun=1 after 2nd stop;
//    clr_err -> overrun=0.
//  3 div=16, 0x55 with stop bit driven 0 -> frame_err=1, rx_valid stays 0; next good 0x0F received OK.
//  4 div=16, rx_in low pulse of 4 cycles -> START aborts to IDLE, busy drops, no valid, no flags.
//  5 div=16, 0xFF; change divisor to 8 and pulse rx_en=0 mid-frame -> no valid;
//    then a div=8 frame 0x81 -> rx_data=0x81.
//  6 div=2 (clamped to 4) 0x96 -> received correctly; assert rst mid-frame -> all outputs 0 in same cycle.

Source files
------------

// File: rtl/uart_rx_controller.sv
`timescale 1ns/1ps
// UART receive sequencer: synchronizes rx_in, times mid-bit samples from a runtime
// baud divisor, shifts DATA_BITS LSB-first, checks the stop bit and hands the byte off via valid/ready.
module uart_rx_controller #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx_in,
  input  logic [DIV_W-1:0]     baud_divisor,
  input  logic                 rx_ready,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int               BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(4);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_s_d;
  logic                   fall;
  logic [DIV_W-1:0]       div_eff;
  logic [DIV_W-1:0]       div_q;
  logic [DIV_W-1:0]       cnt;
  logic [DIV_W-1:0]       target;
  logic                   tick;
  logic [BIT_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shreg;

  logic start_frame;
  logic start_ok;
  logic shift_en;
  logic load_byte;
  logic set_overrun;
  logic set_frame_err;

  // NOTE: the synchronizer resets to 1 (idle line) so leaving reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      rx_s_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_s_d <= rx_s;
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign fall    = !rx_s && rx_s_d;
  assign div_eff = (baud_divisor < DIV_MIN) ? DIV_MIN : baud_divisor;

  // Start bit is checked half a bit in; every later sample is one full bit apart.
  assign target = (state == ST_START) ? (div_q >> 1) : div_q;
  assign tick   = (cnt == target - DIV_W'(1));
  assign busy   = (state != ST_IDLE);

  // NOTE: state and all other flops below use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next    = state;
    start_frame   = 1'b0;
    start_ok      = 1'b0;
    shift_en      = 1'b0;
    load_byte     = 1'b0;
    set_overrun   = 1'b0;
    set_frame_err = 1'b0;
    if (!rx_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state_next  = ST_START;
            start_frame = 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state_next = ST_IDLE;
            end else begin
              state_next = ST_DATA;
              start_ok   = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_en = 1'b1;
            if (bit_idx == LAST_BIT) begin
              state_next = ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            state_next = ST_IDLE;
            if (!rx_s) begin
              set_frame_err = 1'b1;
            end else if (rx_valid) begin
              set_overrun = 1'b1;
            end else begin
              load_byte = 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_q   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= (state == ST_IDLE || state_next == ST_IDLE || tick) ? '0 : cnt + DIV_W'(1);
      if (start_frame) begin
        div_q <= div_eff;
      end
      if (start_ok) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + BIT_W'(1);
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_byte) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      // A set event in the same cycle as clr_err leaves the flag set.
      if (set_frame_err) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_controller: stimulus pushes expected bytes and their due cycle,
// a monitor pops and compares whenever rx_valid rises; flags are checked against directed values.
module tb_uart_rx_controller;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DIV_W       = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rx_en;
  logic                 rx_in;
  logic [DIV_W-1:0]     baud_divisor;
  logic                 rx_ready;
  logic                 clr_err;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb_q[$];

  uart_rx_controller #(
    .DATA_BITS  (DATA_BITS),
    .SYNC_STAGES(SYNC_STAGES),
    .DIV_W      (DIV_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_en       (rx_en),
    .rx_in       (rx_in),
    .baud_divisor(baud_divisor),
    .rx_ready    (rx_ready),
    .clr_err     (clr_err),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; drives one 8N1 frame with div clk cycles per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int div,
                            input bit expect_byte, input int lat);
    exp_t e;
    rx_in = 1'b0;
    if (expect_byte) begin
      e.data = b;
      e.due  = cyc + lat;
      sb_q.push_back(e);
    end
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (div) @(negedge clk);
    end
    rx_in = stop;
    repeat (div) @(negedge clk);
    rx_in = 1'b1;
  endtask

  initial begin : monitor
    logic       vp;
    logic [7:0] held;
    exp_t       e;
    vp   = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst && rx_valid && !vp) begin
        check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("valid_latency_cycle", cyc, e.due);
        end
        held = rx_data;
      end else if (!rst && rx_valid && vp) begin
        check("data_stable", 32'(rx_data), 32'(held));
      end
      vp = rx_valid && !rst;
    end
  end

  initial begin
    rst          = 1'b1;
    rx_en        = 1'b1;
    rx_in        = 1'b1;
    rx_ready     = 1'b1;
    clr_err      = 1'b0;
    baud_divisor = 16;
    idle(3);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(4);

    // 0xA5 at div 16, consumer ready: one-cycle valid, 155-cycle latency.
    send_frame(8'hA5, 1'b1, 16, 1'b1, 155);
    check("t1_valid_dropped", 32'(rx_valid), 0);
    check("t1_data_kept", 32'(rx_data), 32'h A5);
    check("t1_busy", 32'(busy), 0);
    check("t1_frame_err", 32'(frame_err), 0);
    check("t1_overrun", 32'(overrun), 0);

    // Back-to-back frames with consumer stalled: first byte held, second is an overrun.
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 16, 1'b1, 155);
    send_frame(8'hC3, 1'b1, 16, 1'b0, 0);
    check("t2_valid_held", 32'(rx_valid), 1);
    check("t2_data_held", 32'(rx_data), 32'h3C);
    check("t2_overrun", 32'(overrun), 1);
    check("t2_frame_err", 32'(frame_err), 0);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    check("t2_overrun_cleared", 32'(overrun), 0);
    check("t2_valid_after_clr", 32'(rx_valid), 1);
    rx_ready = 1'b1;
    idle(1);
    check("t2_valid_consumed", 32'(rx_valid), 0);
    idle(4);

    // Bad stop bit, then a good frame.
    send_frame(8'h55, 1'b0, 16, 1'b0, 0);
    idle(4);
    check("t3_frame_err", 32'(frame_err), 1);
    check("t3_no_valid", 32'(rx_valid), 0);
    check("t3_overrun", 32'(overrun), 0);
    send_frame(8'h0F, 1'b1, 16, 1'b1, 155);
    idle(2);
    check("t3_frame_err_sticky", 32'(frame_err), 1);
    check("t3_data", 32'(rx_data), 32'h0F);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    check("t3_frame_err_cleared", 32'(frame_err), 0);
    idle(4);

    // 4-cycle glitch: START aborts at its mid-bit sample.
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(2);
    check("t4_busy_in_start", 32'(busy), 1);
    idle(14);
    check("t4_busy_dropped", 32'(busy), 0);
    check("t4_no_valid", 32'(rx_valid), 0);
    check("t4_frame_err", 32'(frame_err), 0);
    check("t4_overrun", 32'(overrun), 0);

    // 0xFF aborted by rx_en=0 mid-frame, divisor changed mid-frame; then a div 8 frame.
    rx_in = 1'b0;
    idle(16);
    rx_in = 1'b1;
    idle(24);
    check("t5_busy_mid_frame", 32'(busy), 1);
    baud_divisor = 8;
    rx_en = 1'b0;
    idle(1);
    rx_en = 1'b1;
    check("t5_abort_idle", 32'(busy), 0);
    idle(130);
    check("t5_no_valid", 32'(rx_valid), 0);
    check("t5_frame_err", 32'(frame_err), 0);
    check("t5_overrun", 32'(overrun), 0);
    send_frame(8'h81, 1'b1, 8, 1'b1, 79);
    idle(2);
    check("t5_data", 32'(rx_data), 32'h81);

    // Divisor 2 clamps to 4; then async reset mid-frame with a byte held.
    baud_divisor = 2;
    rx_ready = 1'b0;
    send_frame(8'h96, 1'b1, 4, 1'b1, 41);
    idle(2);
    check("t6_valid_held", 32'(rx_valid), 1);
    check("t6_data", 32'(rx_data), 32'h96);
    rx_in = 1'b0;
    idle(10);
    check("t6_busy_mid_frame", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_rx_valid", 32'(rx_valid), 0);
    check("t6_rst_rx_data", 32'(rx_data), 0);
    check("t6_rst_frame_err", 32'(frame_err), 0);
    check("t6_rst_overrun", 32'(overrun), 0);
    check("t6_rst_busy", 32'(busy), 0);
    rx_in = 1'b1;
    idle(1);
    rst      = 1'b0;
    rx_ready = 1'b1;
    idle(20);
    check("t6_post_rst_busy", 32'(busy), 0);
    check("t6_post_rst_valid", 32'(rx_valid), 0);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
